// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;

  // Bit positions within mouse packet byte 0
  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_M = 2;
  localparam int unsigned ALIGN = 3;
  localparam int unsigned XSIGN = 4;
  localparam int unsigned YSIGN = 5;
  localparam int unsigned XOVF  = 6;
  localparam int unsigned YOVF  = 7;

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 byte receiver: pin synchronisers, optional clock glitch filter
// (PS2_GLITCH_FILTER_EN), falling-edge detect and 11-bit frame FSM.
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       abort_i,
  output logic                       fall_o,
  output logic                       busy_o,
  output logic                       byte_valid_o,
  output logic                       byte_err_o,
  output logic                       start_err_o,
  output logic [FRAME_DATA_BITS-1:0] byte_o
);

  localparam int unsigned BCW = $clog2(FRAME_DATA_BITS);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   clk_prev_q;
  logic                   fall;

  // Bus idles high, so synchronisers reset high to avoid a false edge
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q[0]  <= ps2_clk;
      data_sync_q[0] <= ps2_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        clk_sync_q[i]  <= clk_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);

  logic [FCW-1:0]           flt_cnt_q, flt_cnt_d;
  logic                     flt_q, flt_d;
  logic [FILTER_CYCLES-1:0] data_dly_q;

  // Filtered clock flips only after FILTER_CYCLES consecutive differing samples
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_sync_q[SYNC_STAGES-1] != flt_q) begin
      if (flt_cnt_q == FCW'(FILTER_CYCLES - 1)) begin
        flt_d = ~flt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      flt_q      <= 1'b1;
      flt_cnt_q  <= '0;
      data_dly_q <= '1;
    end else begin
      flt_q         <= flt_d;
      flt_cnt_q     <= flt_cnt_d;
      data_dly_q[0] <= data_sync_q[SYNC_STAGES-1];
      for (int unsigned i = 1; i < FILTER_CYCLES; i++) begin
        data_dly_q[i] <= data_dly_q[i-1];
      end
    end
  end

  assign clk_s  = flt_q;
  assign data_s = data_dly_q[FILTER_CYCLES-1];
`else
  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) clk_prev_q <= 1'b1;
    else        clk_prev_q <= clk_s;
  end

  assign fall = clk_prev_q & ~clk_s;

  frame_state_e               state_q, state_d;
  logic [BCW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic                       parity_q, parity_d;
  logic [FRAME_DATA_BITS-1:0] byte_q, byte_d;
  logic                       byte_valid_q, byte_valid_d;
  logic                       byte_err_q, byte_err_d;
  logic                       start_err_q, start_err_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    start_err_d  = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            start_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {data_s, shift_q[FRAME_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(FRAME_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_s && (^{shift_q, parity_q})) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            byte_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (abort_i) begin
      // A coincident edge takes priority over the timeout abort
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
      start_err_q  <= start_err_d;
    end
  end

  assign fall_o       = fall;
  assign busy_o       = (state_q != IDLE);
  assign byte_valid_o = byte_valid_q;
  assign byte_err_o   = byte_err_q;
  assign start_err_o  = start_err_q;
  assign byte_o       = byte_q;

endmodule

// File: rtl/ps2_packet_rx.sv
// PS/2 mouse packet receiver: assembles 3-byte packets with an inactivity
// timeout. Optional clock glitch filter enabled by PS2_GLITCH_FILTER_EN.
module ps2_packet_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned FILTER_CYCLES  = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       packet_valid,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                       fall;
  logic                       busy;
  logic                       byte_valid;
  logic                       byte_err;
  logic                       start_err;
  logic [FRAME_DATA_BITS-1:0] rx_byte;
  logic                       timeout;

  ps2_byte_rx #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_byte_rx (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .abort_i     (timeout),
    .fall_o      (fall),
    .busy_o      (busy),
    .byte_valid_o(byte_valid),
    .byte_err_o  (byte_err),
    .start_err_o (start_err),
    .byte_o      (rx_byte)
  );

  logic [1:0]                 idx_q, idx_d;
  logic [FRAME_DATA_BITS-1:0] b0_q, b0_d;
  logic [FRAME_DATA_BITS-1:0] b1_q, b1_d;
  logic [TW-1:0]              to_cnt_q, to_cnt_d;
  logic                       pv_q, pv_d;
  logic                       ferr_q, ferr_d;
  logic [8:0]                 dx_q, dx_d;
  logic [8:0]                 dy_q, dy_d;
  logic                       btn_l_q, btn_l_d;
  logic                       btn_r_q, btn_r_d;
  logic                       btn_m_q, btn_m_d;
  logic                       xovf_q, xovf_d;
  logic                       yovf_q, yovf_d;

  always_comb begin
    idx_d    = idx_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    to_cnt_d = to_cnt_q;
    pv_d     = 1'b0;
    ferr_d   = 1'b0;
    dx_d     = dx_q;
    dy_d     = dy_q;
    btn_l_d  = btn_l_q;
    btn_r_d  = btn_r_q;
    btn_m_d  = btn_m_q;
    xovf_d   = xovf_q;
    yovf_d   = yovf_q;
    timeout  = 1'b0;

    if (fall) begin
      to_cnt_d = '0;
    end else if (busy || (idx_q != 2'd0)) begin
      if (to_cnt_q == TO_LAST) begin
        timeout  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end

    if (start_err) ferr_d = 1'b1;

    if (byte_err) begin
      ferr_d = 1'b1;
      idx_d  = 2'd0;
    end else if (byte_valid) begin
      case (idx_q)
        2'd0: begin
          if (rx_byte[ALIGN]) begin
            b0_d  = rx_byte;
            idx_d = 2'd1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        2'd1: begin
          b1_d  = rx_byte;
          idx_d = 2'd2;
        end
        default: begin
          idx_d   = 2'd0;
          pv_d    = 1'b1;
          dx_d    = {b0_q[XSIGN], b1_q};
          dy_d    = {b0_q[YSIGN], rx_byte};
          btn_l_d = b0_q[BTN_L];
          btn_r_d = b0_q[BTN_R];
          btn_m_d = b0_q[BTN_M];
          xovf_d  = b0_q[XOVF];
          yovf_d  = b0_q[YOVF];
        end
      endcase
    end

    if (timeout) idx_d = 2'd0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q    <= 2'd0;
      b0_q     <= '0;
      b1_q     <= '0;
      to_cnt_q <= '0;
      pv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      btn_l_q  <= 1'b0;
      btn_r_q  <= 1'b0;
      btn_m_q  <= 1'b0;
      xovf_q   <= 1'b0;
      yovf_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      to_cnt_q <= to_cnt_d;
      pv_q     <= pv_d;
      ferr_q   <= ferr_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      btn_l_q  <= btn_l_d;
      btn_r_q  <= btn_r_d;
      btn_m_q  <= btn_m_d;
      xovf_q   <= xovf_d;
      yovf_q   <= yovf_d;
    end
  end

  assign packet_valid = pv_q;
  assign frame_err    = ferr_q;
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign btn_left     = btn_l_q;
  assign btn_right    = btn_r_q;
  assign btn_middle   = btn_m_q;
  assign x_ovf        = xovf_q;
  assign y_ovf        = yovf_q;

endmodule
